// File: rtl/soc_bus_arb2_if.sv
// Single-cycle stb/ack memory bus. The requester uses the master modport and the
// responder uses the slave modport. err is driven only by arbiter-side slaves.
interface soc_bus_arb2_if;
  logic        stb;
  logic [31:0] addr;
  logic        rw;
  logic [31:0] dtw;
  logic        ack;
  logic [31:0] dtr;
  logic        err;

  modport master (
    output stb, addr, rw, dtw,
    input  ack, dtr
  );

  modport slave (
    input  stb, addr, rw, dtw,
    output ack, dtr, err
  );
endinterface

// File: rtl/soc_bus_arb2.sv
// Two-master stb/ack bus arbiter with round-robin or fixed priority and a
// watchdog that forces an error completion when the downstream slave never acks.
module soc_bus_arb2 #(
  parameter int          PRIO_MODE = 0,
  parameter int          TIMEOUT   = 255,
  parameter int          TO_BITS   = 8,
  parameter logic [31:0] ERR_DATA  = 32'hDEADBEEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  soc_bus_arb2_if.slave        m0,
  soc_bus_arb2_if.slave        m1,
  soc_bus_arb2_if.master       s,
  output logic                 owner,
  output logic                 busy
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [TO_BITS-1:0] TO_LIM = TO_BITS'(TIMEOUT);
  localparam bit                 TO_EN  = (TIMEOUT != 0);

  state_t             state;
  logic               pend0, pend1;
  logic [31:0]        addr0_q, dtw0_q, addr1_q, dtw1_q;
  logic               rw0_q, rw1_q;
  logic               last;
  logic [TO_BITS-1:0] cnt;

  logic               req0, req1;
  logic               win;
  logic [31:0]        sel_addr, sel_dtw;
  logic               sel_rw;
  logic               timeout_hit;

  // Returns the index of the winning master; only meaningful when r0 | r1.
  function automatic logic pick(input logic r0, input logic r1, input logic lst);
    if (PRIO_MODE != 0) return !r0;
    if (r0 && r1)       return !lst;
    return !r0;
  endfunction

  // A fresh strobe bypasses the request register so it can issue in its own cycle.
  always_comb begin
    req0     = pend0 | m0.stb;
    req1     = pend1 | m1.stb;
    win      = pick(req0, req1, last);
    sel_addr = pend0 ? addr0_q : m0.addr;
    sel_rw   = pend0 ? rw0_q   : m0.rw;
    sel_dtw  = pend0 ? dtw0_q  : m0.dtw;
    if (win) begin
      sel_addr = pend1 ? addr1_q : m1.addr;
      sel_rw   = pend1 ? rw1_q   : m1.rw;
      sel_dtw  = pend1 ? dtw1_q  : m1.dtw;
    end
    timeout_hit = TO_EN && (cnt == TO_LIM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pend0   <= 1'b0;
      pend1   <= 1'b0;
      addr0_q <= '0;
      dtw0_q  <= '0;
      rw0_q   <= 1'b0;
      addr1_q <= '0;
      dtw1_q  <= '0;
      rw1_q   <= 1'b0;
      last    <= 1'b1;
      cnt     <= '0;
      owner   <= 1'b0;
      busy    <= 1'b0;
      s.stb   <= 1'b0;
      s.addr  <= '0;
      s.rw    <= 1'b0;
      s.dtw   <= '0;
      m0.ack  <= 1'b0;
      m0.err  <= 1'b0;
      m0.dtr  <= '0;
      m1.ack  <= 1'b0;
      m1.err  <= 1'b0;
      m1.dtr  <= '0;
    end else begin
      s.stb  <= 1'b0;
      m0.ack <= 1'b0;
      m0.err <= 1'b0;
      m1.ack <= 1'b0;
      m1.err <= 1'b0;

      // A strobe from an already-pending master is dropped.
      if (m0.stb && !pend0) begin
        pend0   <= 1'b1;
        addr0_q <= m0.addr;
        rw0_q   <= m0.rw;
        dtw0_q  <= m0.dtw;
      end
      if (m1.stb && !pend1) begin
        pend1   <= 1'b1;
        addr1_q <= m1.addr;
        rw1_q   <= m1.rw;
        dtw1_q  <= m1.dtw;
      end

      case (state)
        IDLE: begin
          if (req0 || req1) begin
            s.stb  <= 1'b1;
            s.addr <= sel_addr;
            s.rw   <= sel_rw;
            s.dtw  <= sel_dtw;
            owner  <= win;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt + TO_BITS'(1);
          // A real ack on the watchdog's last cycle takes precedence over the error.
          if (s.ack || timeout_hit) begin
            if (owner) begin
              m1.ack <= 1'b1;
              m1.err <= !s.ack;
              m1.dtr <= s.ack ? s.dtr : ERR_DATA;
              pend1  <= 1'b0;
            end else begin
              m0.ack <= 1'b1;
              m0.err <= !s.ack;
              m0.dtr <= s.ack ? s.dtr : ERR_DATA;
              pend0  <= 1'b0;
            end
            last  <= owner;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_soc_bus_arb2.sv
// Directed bench for soc_bus_arb2: instance A is round-robin with TIMEOUT=4,
// instance B is fixed priority with the watchdog disabled.
module tb_soc_bus_arb2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic a_owner, a_busy, b_owner, b_busy;
  int   n_chk = 0;
  int   n_fail = 0;

  soc_bus_arb2_if a_m0 ();
  soc_bus_arb2_if a_m1 ();
  soc_bus_arb2_if a_s ();
  soc_bus_arb2_if b_m0 ();
  soc_bus_arb2_if b_m1 ();
  soc_bus_arb2_if b_s ();

  soc_bus_arb2 #(.PRIO_MODE(0), .TIMEOUT(4), .TO_BITS(8), .ERR_DATA(32'hDEADBEEF)) dut_a (
    .clk(clk), .rst_n(rst_n), .m0(a_m0), .m1(a_m1), .s(a_s), .owner(a_owner), .busy(a_busy)
  );

  soc_bus_arb2 #(.PRIO_MODE(1), .TIMEOUT(0), .TO_BITS(8), .ERR_DATA(32'hDEADBEEF)) dut_b (
    .clk(clk), .rst_n(rst_n), .m0(b_m0), .m1(b_m1), .s(b_s), .owner(b_owner), .busy(b_busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    a_m0.stb = 0; a_m0.addr = 0; a_m0.rw = 0; a_m0.dtw = 0;
    a_m1.stb = 0; a_m1.addr = 0; a_m1.rw = 0; a_m1.dtw = 0;
    a_s.ack = 0; a_s.dtr = 0; a_s.err = 0;
    b_m0.stb = 0; b_m0.addr = 0; b_m0.rw = 0; b_m0.dtw = 0;
    b_m1.stb = 0; b_m1.addr = 0; b_m1.rw = 0; b_m1.dtw = 0;
    b_s.ack = 0; b_s.dtr = 0; b_s.err = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    tick();
    tick();
    // Reset state of instance A.
    chk("rst s_stb",  {31'd0, a_s.stb}, 32'd0);
    chk("rst s_addr", a_s.addr, 32'd0);
    chk("rst s_rw",   {31'd0, a_s.rw}, 32'd0);
    chk("rst s_dtw",  a_s.dtw, 32'd0);
    chk("rst owner",  {31'd0, a_owner}, 32'd0);
    chk("rst busy",   {31'd0, a_busy}, 32'd0);
    chk("rst m0_ack", {31'd0, a_m0.ack}, 32'd0);
    chk("rst m0_dtr", a_m0.dtr, 32'd0);
    chk("rst m0_err", {31'd0, a_m0.err}, 32'd0);
    chk("rst m1_ack", {31'd0, a_m1.ack}, 32'd0);
    chk("rst m1_dtr", a_m1.dtr, 32'd0);
    chk("rst m1_err", {31'd0, a_m1.err}, 32'd0);
    rst_n = 1;
    tick();

    // Single read from m0, slave acks two cycles after s_stb.
    a_m0.stb = 1; a_m0.addr = 32'h100; a_m0.rw = 0;
    tick();
    a_m0.stb = 0;
    chk("single s_stb",  {31'd0, a_s.stb}, 32'd1);
    chk("single s_addr", a_s.addr, 32'h100);
    chk("single s_rw",   {31'd0, a_s.rw}, 32'd0);
    chk("single owner",  {31'd0, a_owner}, 32'd0);
    chk("single busy",   {31'd0, a_busy}, 32'd1);
    tick();
    chk("single s_stb pulse", {31'd0, a_s.stb}, 32'd0);
    tick();
    a_s.ack = 1; a_s.dtr = 32'h12345678;
    tick();
    a_s.ack = 0;
    chk("single m0_ack", {31'd0, a_m0.ack}, 32'd1);
    chk("single m0_dtr", a_m0.dtr, 32'h12345678);
    chk("single m0_err", {31'd0, a_m0.err}, 32'd0);
    chk("single m1_ack", {31'd0, a_m1.ack}, 32'd0);
    chk("single busy end", {31'd0, a_busy}, 32'd0);
    tick();
    chk("single m0_ack pulse", {31'd0, a_m0.ack}, 32'd0);
    chk("single m0_dtr hold", a_m0.dtr, 32'h12345678);

    // Simultaneous requests from reset alternate m0, m1, m0, m1, ...
    do_reset();
    for (int i = 0; i < 3; i++) begin
      a_m0.stb = 1; a_m0.addr = 32'h1000 + 32'(i * 16);
      a_m1.stb = 1; a_m1.addr = 32'h2000 + 32'(i * 16);
      tick();
      a_m0.stb = 0; a_m1.stb = 0;
      chk("rr m0 s_stb",  {31'd0, a_s.stb}, 32'd1);
      chk("rr m0 s_addr", a_s.addr, 32'h1000 + 32'(i * 16));
      chk("rr m0 owner",  {31'd0, a_owner}, 32'd0);
      tick();
      a_s.ack = 1; a_s.dtr = 32'hA000 + 32'(i);
      tick();
      a_s.ack = 0;
      chk("rr m0_ack", {31'd0, a_m0.ack}, 32'd1);
      chk("rr m0_dtr", a_m0.dtr, 32'hA000 + 32'(i));
      chk("rr m1_ack idle", {31'd0, a_m1.ack}, 32'd0);
      tick();
      chk("rr m1 s_stb",  {31'd0, a_s.stb}, 32'd1);
      chk("rr m1 s_addr", a_s.addr, 32'h2000 + 32'(i * 16));
      chk("rr m1 owner",  {31'd0, a_owner}, 32'd1);
      a_s.ack = 1; a_s.dtr = 32'hB000 + 32'(i);
      tick();
      a_s.ack = 0;
      chk("rr m1_ack", {31'd0, a_m1.ack}, 32'd1);
      chk("rr m1_dtr", a_m1.dtr, 32'hB000 + 32'(i));
      chk("rr m0_dtr undisturbed", a_m0.dtr, 32'hA000 + 32'(i));
      chk("rr m0_ack quiet", {31'd0, a_m0.ack}, 32'd0);
    end
    tick();

    // Watchdog expiry on an m1 read.
    a_m1.stb = 1; a_m1.addr = 32'h300; a_m1.rw = 0;
    tick();
    a_m1.stb = 0;
    chk("to s_stb", {31'd0, a_s.stb}, 32'd1);
    chk("to owner", {31'd0, a_owner}, 32'd1);
    tick(); tick(); tick(); tick();
    chk("to m1_ack early", {31'd0, a_m1.ack}, 32'd0);
    chk("to busy before", {31'd0, a_busy}, 32'd1);
    tick();
    chk("to m1_ack", {31'd0, a_m1.ack}, 32'd1);
    chk("to m1_err", {31'd0, a_m1.err}, 32'd1);
    chk("to m1_dtr", a_m1.dtr, 32'hDEADBEEF);
    chk("to busy",   {31'd0, a_busy}, 32'd0);
    a_s.ack = 1; a_s.dtr = 32'h99999999;
    tick();
    a_s.ack = 0;
    chk("late ack m1_ack", {31'd0, a_m1.ack}, 32'd0);
    chk("late ack m0_ack", {31'd0, a_m0.ack}, 32'd0);
    chk("late ack m1_dtr", a_m1.dtr, 32'hDEADBEEF);
    chk("late ack s_stb",  {31'd0, a_s.stb}, 32'd0);
    a_m1.stb = 1; a_m1.addr = 32'h304;
    tick();
    a_m1.stb = 0;
    chk("after to s_stb",  {31'd0, a_s.stb}, 32'd1);
    chk("after to s_addr", a_s.addr, 32'h304);
    tick();
    a_s.ack = 1; a_s.dtr = 32'h55AA55AA;
    tick();
    a_s.ack = 0;
    chk("after to m1_ack", {31'd0, a_m1.ack}, 32'd1);
    chk("after to m1_err", {31'd0, a_m1.err}, 32'd0);
    chk("after to m1_dtr", a_m1.dtr, 32'h55AA55AA);

    // Ack on exactly the watchdog's last cycle completes normally.
    a_m0.stb = 1; a_m0.addr = 32'h200;
    tick();
    a_m0.stb = 0;
    tick(); tick(); tick(); tick();
    a_s.ack = 1; a_s.dtr = 32'h0BADF00D;
    tick();
    a_s.ack = 0;
    chk("bound m0_ack", {31'd0, a_m0.ack}, 32'd1);
    chk("bound m0_err", {31'd0, a_m0.err}, 32'd0);
    chk("bound m0_dtr", a_m0.dtr, 32'h0BADF00D);

    // Reset during WAIT with m0 pending.
    a_m1.stb = 1; a_m1.addr = 32'h400; a_m1.rw = 1; a_m1.dtw = 32'h77;
    tick();
    a_m1.stb = 0;
    chk("mid s_addr", a_s.addr, 32'h400);
    chk("mid s_rw",   {31'd0, a_s.rw}, 32'd1);
    chk("mid s_dtw",  a_s.dtw, 32'h77);
    chk("mid owner",  {31'd0, a_owner}, 32'd1);
    a_m0.stb = 1; a_m0.addr = 32'h500;
    tick();
    a_m0.stb = 0;
    chk("mid busy", {31'd0, a_busy}, 32'd1);
    rst_n = 0;
    #1;
    chk("mid rst busy",   {31'd0, a_busy}, 32'd0);
    chk("mid rst owner",  {31'd0, a_owner}, 32'd0);
    chk("mid rst s_addr", a_s.addr, 32'd0);
    chk("mid rst s_rw",   {31'd0, a_s.rw}, 32'd0);
    chk("mid rst s_dtw",  a_s.dtw, 32'd0);
    chk("mid rst m1_dtr", a_m1.dtr, 32'd0);
    tick();
    tick();
    rst_n = 1;
    a_s.ack = 1;
    tick();
    a_s.ack = 0;
    for (int i = 0; i < 3; i++) begin
      chk("post rst m0_ack", {31'd0, a_m0.ack}, 32'd0);
      chk("post rst m1_ack", {31'd0, a_m1.ack}, 32'd0);
      chk("post rst s_stb",  {31'd0, a_s.stb}, 32'd0);
      tick();
    end
    a_m1.stb = 1; a_m1.addr = 32'h600; a_m1.rw = 0;
    tick();
    a_m1.stb = 0;
    chk("post rst issue s_stb",  {31'd0, a_s.stb}, 32'd1);
    chk("post rst issue s_addr", a_s.addr, 32'h600);
    chk("post rst issue owner",  {31'd0, a_owner}, 32'd1);
    tick();
    a_s.ack = 1; a_s.dtr = 32'h66;
    tick();
    a_s.ack = 0;
    chk("post rst m1_ack", {31'd0, a_m1.ack}, 32'd1);
    chk("post rst m1_dtr", a_m1.dtr, 32'h66);

    // Fixed priority: m1 waits while m0 re-requests on each of its acks.
    do_reset();
    b_m0.stb = 1; b_m0.addr = 32'h10;
    b_m1.stb = 1; b_m1.addr = 32'h20;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("prio m0 s_stb",  {31'd0, b_s.stb}, 32'd1);
      chk("prio m0 s_addr", b_s.addr, 32'h10 + 32'(i * 4));
      chk("prio m0 owner",  {31'd0, b_owner}, 32'd0);
      b_m0.stb = 0; b_m1.stb = 0;
      tick();
      b_s.ack = 1; b_s.dtr = 32'hC000 + 32'(i);
      tick();
      b_s.ack = 0;
      chk("prio m0_ack", {31'd0, b_m0.ack}, 32'd1);
      chk("prio m0_dtr", b_m0.dtr, 32'hC000 + 32'(i));
      chk("prio m1_ack idle", {31'd0, b_m1.ack}, 32'd0);
      if (i < 3) begin
        b_m0.stb = 1; b_m0.addr = 32'h10 + 32'((i + 1) * 4);
      end
      tick();
    end
    chk("prio m1 s_stb",  {31'd0, b_s.stb}, 32'd1);
    chk("prio m1 s_addr", b_s.addr, 32'h20);
    chk("prio m1 owner",  {31'd0, b_owner}, 32'd1);
    tick();
    b_s.ack = 1; b_s.dtr = 32'hD00D;
    tick();
    b_s.ack = 0;
    chk("prio m1_ack", {31'd0, b_m1.ack}, 32'd1);
    chk("prio m1_dtr", b_m1.dtr, 32'hD00D);
    chk("prio m1_err", {31'd0, b_m1.err}, 32'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/soc_bus_arb2.md
# soc_bus_arb2

Two-master arbiter that shares one stb/ack memory bus between two requesters, for example the hs32 CPU and a DMA or UART boot loader, ahead of the device interconnect or BRAM controller. It latches one single-cycle request per master and issues requests downstream one at a time. It selects a winner by round-robin or fixed priority and returns the data and ack to the owning master. A watchdog terminates any downstream transaction the slave never acknowledges.

## Interface
- PRIO_MODE, 0; 0 = round-robin, 1 = fixed priority (m0 always wins).
- TIMEOUT, 255; number of WAIT cycles before a forced error completion; 0 disables the watchdog.
- TO_BITS, 8; width of the timeout counter; TIMEOUT must be less than 2^TO_BITS.
- ERR_DATA, 32'hDEADBEEF; value returned on m*_dtr when a transaction times out.
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- m0_stb, m1_stb  in  1  single-cycle request strobe.
- m0_addr, m1_addr  in  32  request address, sampled in the stb cycle.
- m0_rw, m1_rw  in  1  1 = write, sampled in the stb cycle.
- m0_dtw, m1_dtw  in  32  write data, sampled in the stb cycle.
- m0_ack, m1_ack  out  1  single-cycle completion pulse.
- m0_dtr, m1_dtr  out  32  read data, valid while the matching ack is high.
- m0_err, m1_err  out  1  high with ack when the transaction timed out.
- s_stb  out  1  single-cycle downstream strobe.
- s_addr  out  32  downstream address.
- s_rw  out  1  downstream write flag.
- s_dtw  out  32  downstream write data.
- s_ack  in  1  downstream completion.
- s_dtr  in  32  downstream read data, sampled with s_ack.
- owner  out  1  index of the master granted last.
- busy  out  1  high while the FSM is in WAIT.

## Operation
- Each master has a request register (addr, rw, dtw) and a pending flag.
- An m*_stb while that master is not pending loads its register and sets pending.
- An m*_stb while that master is already pending is ignored; the register stays unchanged.
- FSM states are IDLE and WAIT.
- IDLE: the request set is (pending | stb) per master, so a new stb bypasses the register.
  - If the set is non-empty, select a winner, drive s_addr/s_rw/s_dtw from it, pulse s_stb, set owner, clear the timeout counter and go to WAIT.
- Winner selection:
  - PRIO_MODE=1: m0 wins whenever it requests.
  - PRIO_MODE=0 with one requester: that requester wins.
  - PRIO_MODE=0 with both requesting: the master that is not `last` wins.
- WAIT: the timeout counter increments every cycle.
  - On s_ack: register s_dtr into the owner's m*_dtr, pulse the owner's m*_ack with err=0, clear the owner's pending flag, set last <= owner, go to IDLE.
  - If TIMEOUT≠0, the counter reaches TIMEOUT and s_ack is low: m*_dtr <= ERR_DATA, pulse m*_ack with err=1, clear pending, set last <= owner, go to IDLE.
  - If s_ack arrives in the same cycle the counter reaches TIMEOUT, normal completion wins.
- An s_ack received in IDLE is a stray or late ack and is ignored.
- s_addr/s_rw/s_dtw hold their values from issue until the next issue.
- m*_dtr holds its value until the next completion for that master.
- The non-owner master's ack, err and dtr are never disturbed by the owner's completion.
- Reset values: all outputs 0, state IDLE, both pending flags 0, last=1 (so m0 wins the first tie).
- Reset asserted mid-transaction discards pending requests; no ack is returned for them.

## Timing
- m*_stb at cycle N with the FSM in IDLE: s_stb is high at N+1.
- s_ack at cycle K: m*_ack, m*_dtr and m*_err are valid at K+1, and the FSM is in IDLE at K+1.
- If another request is pending at K+1, its s_stb is high at K+2.
- Minimum turnaround is therefore one idle bus cycle between transactions.
- With a zero-wait slave (s_ack at N+2), m*_ack is high at N+3.
- A master may issue its next stb in its own ack cycle or later; that request is accepted normally.
- Timeout: with s_stb at cycle S and no s_ack, m*_ack with err=1 is high at S+TIMEOUT+1.
- At most one s_stb is outstanding at any time; s_stb and busy are never both high with IDLE state.

## Test plan
- Single read: m0 read at 0x100, slave acks 2 cycles after s_stb with 0x12345678 -> s_stb exactly one cycle after m0_stb; m0_ack one cycle after s_ack with m0_dtr=0x12345678, m0_err=0; m1_ack stays 0.
- Simultaneous requests, PRIO_MODE=0: m0 and m1 stb in the same cycle after reset, then repeat three times -> grant order m0,m1,m0,m1,m0,m1; s_addr matches the granted master's address each time.
- Fixed priority, PRIO_MODE=1: m1 pending while m0 issues back-to-back requests, each on its previous ack -> m1 is never granted while m0 requests; m1 is served after m0 stops.
- Timeout, TIMEOUT=4: slave never acks -> m1_ack with m1_err=1 and m1_dtr=0xDEADBEEF at S+5; a late s_ack is ignored; the next request completes normally.
- Ack at the timeout boundary: s_ack exactly on the TIMEOUT cycle -> err=0 and slave data returned.
- Reset mid-WAIT: assert rst_n low during WAIT with m1 pending, then release -> all outputs 0 immediately; no ack for either master; the first new request issues normally.
